// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache.
// Optional feature macro: CACHE_PERF_CNT_EN (hit/miss counters on the top).
package cache_pkg;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL} state_e;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 30;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int off_w(input int blk_words);
    return $clog2(blk_words);
  endfunction

  function automatic int tag_w(input int sets, input int blk_words);
    return ADDR_W - idx_w(sets) - off_w(blk_words);
  endfunction

  // way index width; a direct-mapped build still carries a 1-bit index
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // tree PLRU needs WAYS-1 bits; WAYS=1 carries one unused bit
  function automatic int plru_w(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// Combinational tree pseudo-LRU for one set. A bit value names the side
// holding the next victim; an access flips the path bits away from that way.
module cache_plru
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int PW   = plru_w(WAYS),
  parameter int WW   = way_w(WAYS)
) (
  input  logic [PW-1:0] bits_i,
  input  logic [WW-1:0] way_i,
  input  logic          upd_i,
  output logic [PW-1:0] bits_o,
  output logic [WW-1:0] victim_o
);

  generate
    if (WAYS == 4) begin : g_w4
      // bit0 picks the pair, bit1/bit2 pick within the left/right pair
      always_comb begin
        bits_o   = bits_i;
        victim_o = bits_i[0] ? {1'b1, bits_i[2]} : {1'b0, bits_i[1]};
        if (upd_i) begin
          bits_o[0] = ~way_i[1];
          if (way_i[1]) bits_o[2] = ~way_i[0];
          else          bits_o[1] = ~way_i[0];
        end
      end
    end else if (WAYS == 2) begin : g_w2
      // single bit points at the way not touched most recently
      always_comb begin
        bits_o   = bits_i;
        victim_o = bits_i[0];
        if (upd_i) bits_o[0] = ~way_i[0];
      end
    end else begin : g_w1
      logic unused_plru;
      assign unused_plru = ^{way_i, upd_i};
      assign bits_o   = bits_i;
      assign victim_o = '0;
    end
  endgenerate

endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative write-back/write-allocate cache with tree PLRU.
// Hits complete combinationally; misses stall through write-back and refill.
// Optional macro CACHE_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
module cache_assoc
  import cache_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SETS      = 4,
  parameter int BLK_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    proc_reset_n,
  input  logic                    proc_read,
  input  logic                    proc_write,
  input  logic [29:0]             proc_addr,
  input  logic [31:0]             proc_wdata,
  output logic [31:0]             proc_rdata,
  output logic                    proc_stall,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [29-off_w(BLK_WORDS):0] mem_addr,
  output logic [32*BLK_WORDS-1:0] mem_wdata,
  input  logic [32*BLK_WORDS-1:0] mem_rdata,
  input  logic                    mem_ready
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
`endif
);

  localparam int IDX = idx_w(SETS);
  localparam int OFF = off_w(BLK_WORDS);
  localparam int TAG = tag_w(SETS, BLK_WORDS);
  localparam int WW  = way_w(WAYS);
  localparam int PW  = plru_w(WAYS);

  // line state: valid/dirty/PLRU reset, tag/data do not
  logic [WAYS-1:0]                  valid_q [SETS];
  logic [WAYS-1:0]                  dirty_q [SETS];
  logic [PW-1:0]                    plru_q  [SETS];
  logic [TAG-1:0]                   tag_q   [SETS][WAYS];
  logic [BLK_WORDS-1:0][WORD_W-1:0] data_q  [SETS][WAYS];

  state_e         state_q, state_d;
  logic [WW-1:0]  victim_q;

  logic [TAG-1:0] req_tag;
  logic [IDX-1:0] req_idx;
  logic [OFF-1:0] req_off;
  assign req_tag = proc_addr[29 -: TAG];
  assign req_idx = proc_addr[OFF +: IDX];
  assign req_off = proc_addr[OFF-1:0];

  logic          acc, hit, has_inv, acc_hit, miss_det, refill_done;
  logic [WW-1:0] hit_way, inv_way, plru_victim, victim_sel;
  logic [PW-1:0] plru_nxt;

  assign acc = proc_read | proc_write;

  // parallel tag compare plus lowest-index invalid way search
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[req_idx][w]) begin
        has_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  assign acc_hit     = (state_q == S_IDLE) & acc & hit;
  assign miss_det    = (state_q == S_IDLE) & acc & ~hit;
  assign refill_done = (state_q == S_REFILL) & mem_ready;
  assign victim_sel  = has_inv ? inv_way : plru_victim;
  assign proc_stall  = acc & ~acc_hit;

  cache_plru #(.WAYS(WAYS), .PW(PW), .WW(WW)) u_plru (
    .bits_i   (plru_q[req_idx]),
    .way_i    (hit_way),
    .upd_i    (acc_hit),
    .bits_o   (plru_nxt),
    .victim_o (plru_victim)
  );

  // FSM state register and victim capture
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_det) victim_q <= victim_sel;
    end
  end

  // FSM next state: dirty victims go through write-back first
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (miss_det)
          state_d = (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel])
                    ? S_WB : S_REFILL;
      end
      S_WB:     if (mem_ready) state_d = S_REFILL;
      S_REFILL: if (mem_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs; everything idles at zero
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    proc_rdata = '0;
    case (state_q)
      S_IDLE: begin
        if (acc_hit && proc_read) proc_rdata = data_q[req_idx][hit_way][req_off];
      end
      S_WB: begin
        // write strobe drops in the completion cycle itself
        mem_write = ~mem_ready;
        mem_addr  = {tag_q[req_idx][victim_q], req_idx};
        mem_wdata = data_q[req_idx][victim_q];
      end
      S_REFILL: begin
        mem_read = 1'b1;
        mem_addr = {req_tag, req_idx};
      end
      default: ;
    endcase
  end

  // line status: PLRU/dirty on hits, valid+clean on refill
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (acc_hit) begin
        plru_q[req_idx] <= plru_nxt;
        if (proc_write) dirty_q[req_idx][hit_way] <= 1'b1;
      end
      if (refill_done) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
      end
    end
  end

  // tag and data arrays
  always_ff @(posedge clk) begin
    if (acc_hit && proc_write) begin
      data_q[req_idx][hit_way][req_off] <= proc_wdata;
    end else if (refill_done) begin
      data_q[req_idx][victim_q] <= mem_rdata;
      tag_q[req_idx][victim_q]  <= req_tag;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_q, miss_q;
  logic        miss_pend_q;

  // counters; a replayed hit after a miss is not counted as a hit
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      hit_q       <= '0;
      miss_q      <= '0;
      miss_pend_q <= 1'b0;
    end else begin
      if (miss_det) begin
        miss_pend_q <= 1'b1;
        if (miss_q != '1) miss_q <= miss_q + 32'd1;
      end
      if (acc_hit) begin
        miss_pend_q <= 1'b0;
        if (!miss_pend_q && hit_q != '1) hit_q <= hit_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`endif

endmodule
